// File: rtl/ysram_port_arbiter.sv
// ysram_port_arbiter
// Shares the Y-memory (two read ports, one write port) between NRD read
// requesters and NWR write requesters. Round-robin grants are combinational.
// Memory addresses, write enable and write data are registered. Read data
// comes back two cycles after the grant and is routed to the requester
// through a per-port tag. Out-of-range addresses are accepted and flagged,
// and never reach the memory.

module ysram_port_arbiter #(
   parameter int NRD    = 4,
   parameter int NWR    = 2,
   parameter int ADDR_W = 11,
   parameter int DATA_W = 256,
   parameter int DEPTH  = 1800
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic [NRD-1:0]        i_rd_req,
   input  logic [NRD*ADDR_W-1:0] i_rd_addr,
   output logic [NRD-1:0]        o_rd_gnt,
   output logic [NRD-1:0]        o_rd_vld,
   output logic [NRD-1:0]        o_rd_err,
   output logic [NRD*DATA_W-1:0] o_rd_data,
   input  logic [NWR-1:0]        i_wr_req,
   input  logic [NWR*ADDR_W-1:0] i_wr_addr,
   input  logic [NWR*DATA_W-1:0] i_wr_data,
   output logic [NWR-1:0]        o_wr_gnt,
   output logic [NWR-1:0]        o_wr_err,
   output logic                  o_mem_we,
   output logic [ADDR_W-1:0]     o_mem_waddr,
   output logic [DATA_W-1:0]     o_mem_wdata,
   output logic [ADDR_W-1:0]     o_mem_raddr1,
   output logic [ADDR_W-1:0]     o_mem_raddr2,
   input  logic [DATA_W-1:0]     i_mem_rdata1,
   input  logic [DATA_W-1:0]     i_mem_rdata2
);

   localparam int RI_W = (NRD > 1) ? $clog2(NRD) : 1;
   localparam int WI_W = (NWR > 1) ? $clog2(NWR) : 1;
   // One extra bit so that DEPTH == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

   function automatic logic f_oor(input logic [ADDR_W-1:0] a);
      return {1'b0, a} >= LP_DEPTH;
   endfunction

   function automatic logic [RI_W-1:0] f_rd_inc(input logic [RI_W-1:0] x);
      return RI_W'((int'(x) + 1) % NRD);
   endfunction

   function automatic logic [WI_W-1:0] f_wr_inc(input logic [WI_W-1:0] x);
      return WI_W'((int'(x) + 1) % NWR);
   endfunction

   // round-robin pointers
   logic [RI_W-1:0] r_rp;
   logic [WI_W-1:0] r_wp;

   // memory-side registers
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_waddr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [ADDR_W-1:0] r_mem_raddr1;
   logic [ADDR_W-1:0] r_mem_raddr2;

   // per-port tags riding alongside the read addresses
   logic            r_t1_vld, r_t2_vld;
   logic [RI_W-1:0] r_t1_idx, r_t2_idx;
   logic            r_t1_err, r_t2_err;

   // response registers
   logic [NRD-1:0]        r_rd_vld;
   logic [NRD-1:0]        r_rd_err;
   logic [NRD*DATA_W-1:0] r_rd_data;

   // read arbitration signals
   logic [NRD-1:0]    w_rd_req;
   logic              w_p1_fnd, w_p2_fnd;
   logic [RI_W-1:0]   w_p1_idx, w_p2_idx, w_rscan;
   logic [ADDR_W-1:0] w_p1_addr, w_p2_addr;
   logic              w_p1_oor, w_p2_oor;
   logic [NRD-1:0]    w_rd_gnt;
   logic [RI_W-1:0]   w_rp_nxt;

   // write arbitration signals
   logic [NWR-1:0]    w_wr_req;
   logic              w_wr_fnd;
   logic [WI_W-1:0]   w_wr_idx, w_wscan;
   logic [ADDR_W-1:0] w_wr_addr;
   logic [DATA_W-1:0] w_wr_data;
   logic              w_wr_oor;
   logic [NWR-1:0]    w_wr_gnt;
   logic [WI_W-1:0]   w_wp_nxt;

   // No grants are issued while reset is held.
   assign w_rd_req = i_reset ? '0 : i_rd_req;
   assign w_wr_req = i_reset ? '0 : i_wr_req;

   // Read scan from rp: the first hit takes port 1, the second takes port 2.
   // Everything between rp and the port-1 winner is idle, so one pass from rp
   // is the same as scanning cyclically onward from the port-1 winner.
   always_comb begin
      w_p1_fnd = 1'b0;
      w_p2_fnd = 1'b0;
      w_p1_idx = '0;
      w_p2_idx = '0;
      w_rscan  = '0;
      for (int k = 0; k < NRD; k++) begin
         w_rscan = RI_W'((int'(r_rp) + k) % NRD);
         if (w_rd_req[w_rscan]) begin
            if (!w_p1_fnd) begin
               w_p1_fnd = 1'b1;
               w_p1_idx = w_rscan;
            end else if (!w_p2_fnd) begin
               w_p2_fnd = 1'b1;
               w_p2_idx = w_rscan;
            end
         end
      end
   end

   assign w_p1_addr = i_rd_addr[int'(w_p1_idx)*ADDR_W +: ADDR_W];
   assign w_p2_addr = i_rd_addr[int'(w_p2_idx)*ADDR_W +: ADDR_W];
   assign w_p1_oor  = f_oor(w_p1_addr);
   assign w_p2_oor  = f_oor(w_p2_addr);

   // Read grant vector and next read pointer.
   always_comb begin
      w_rd_gnt = '0;
      if (w_p1_fnd) w_rd_gnt[w_p1_idx] = 1'b1;
      if (w_p2_fnd) w_rd_gnt[w_p2_idx] = 1'b1;
      if (w_p2_fnd)      w_rp_nxt = f_rd_inc(w_p2_idx);
      else if (w_p1_fnd) w_rp_nxt = f_rd_inc(w_p1_idx);
      else               w_rp_nxt = r_rp;
   end

   // Write scan from wp: a single winner per cycle.
   always_comb begin
      w_wr_fnd = 1'b0;
      w_wr_idx = '0;
      w_wscan  = '0;
      for (int k = 0; k < NWR; k++) begin
         w_wscan = WI_W'((int'(r_wp) + k) % NWR);
         if (w_wr_req[w_wscan] && !w_wr_fnd) begin
            w_wr_fnd = 1'b1;
            w_wr_idx = w_wscan;
         end
      end
   end

   assign w_wr_addr = i_wr_addr[int'(w_wr_idx)*ADDR_W +: ADDR_W];
   assign w_wr_data = i_wr_data[int'(w_wr_idx)*DATA_W +: DATA_W];
   assign w_wr_oor  = f_oor(w_wr_addr);

   // Write grant vector and next write pointer.
   always_comb begin
      w_wr_gnt = '0;
      if (w_wr_fnd) w_wr_gnt[w_wr_idx] = 1'b1;
      w_wp_nxt = w_wr_fnd ? f_wr_inc(w_wr_idx) : r_wp;
   end

   // Round-robin pointer update.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_rp <= '0;
         r_wp <= '0;
      end else begin
         r_rp <= w_rp_nxt;
         r_wp <= w_wp_nxt;
      end
   end

   // Memory-side registers. Out-of-range grants leave addresses untouched.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_mem_we     <= 1'b0;
         r_mem_waddr  <= '0;
         r_mem_wdata  <= '0;
         r_mem_raddr1 <= '0;
         r_mem_raddr2 <= '0;
      end else begin
         r_mem_we <= w_wr_fnd && !w_wr_oor;
         if (w_wr_fnd && !w_wr_oor) begin
            r_mem_waddr <= w_wr_addr;
            r_mem_wdata <= w_wr_data;
         end
         if (w_p1_fnd && !w_p1_oor) r_mem_raddr1 <= w_p1_addr;
         if (w_p2_fnd && !w_p2_oor) r_mem_raddr2 <= w_p2_addr;
      end
   end

   // Tags follow the read addresses by one stage.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_t1_vld <= 1'b0;
         r_t2_vld <= 1'b0;
         r_t1_idx <= '0;
         r_t2_idx <= '0;
         r_t1_err <= 1'b0;
         r_t2_err <= 1'b0;
      end else begin
         r_t1_vld <= w_p1_fnd;
         r_t2_vld <= w_p2_fnd;
         r_t1_idx <= w_p1_idx;
         r_t2_idx <= w_p2_idx;
         r_t1_err <= w_p1_oor;
         r_t2_err <= w_p2_oor;
      end
   end

   // Retire tags: pulse vld/err, capture read data (zero on error).
   // Both ports never carry the same requester in one cycle.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_rd_vld  <= '0;
         r_rd_err  <= '0;
         r_rd_data <= '0;
      end else begin
         r_rd_vld <= '0;
         r_rd_err <= '0;
         if (r_t1_vld) begin
            r_rd_vld[r_t1_idx] <= 1'b1;
            r_rd_err[r_t1_idx] <= r_t1_err;
            r_rd_data[int'(r_t1_idx)*DATA_W +: DATA_W] <= r_t1_err ? '0 : i_mem_rdata1;
         end
         if (r_t2_vld) begin
            r_rd_vld[r_t2_idx] <= 1'b1;
            r_rd_err[r_t2_idx] <= r_t2_err;
            r_rd_data[int'(r_t2_idx)*DATA_W +: DATA_W] <= r_t2_err ? '0 : i_mem_rdata2;
         end
      end
   end

   assign o_rd_gnt     = w_rd_gnt;
   assign o_wr_gnt     = w_wr_gnt;
   assign o_wr_err     = w_wr_gnt & {NWR{w_wr_oor}};
   assign o_rd_vld     = r_rd_vld;
   assign o_rd_err     = r_rd_err;
   assign o_rd_data    = r_rd_data;
   assign o_mem_we     = r_mem_we;
   assign o_mem_waddr  = r_mem_waddr;
   assign o_mem_wdata  = r_mem_wdata;
   assign o_mem_raddr1 = r_mem_raddr1;
   assign o_mem_raddr2 = r_mem_raddr2;

endmodule

// File: tb/tb_ysram_port_arbiter.sv
// Testbench for ysram_port_arbiter: behavioural Y-memory, a table of
// per-cycle vectors for round-robin reads and write fairness, and hand-written
// sequences for read/write ordering, out-of-range and reset mid-flight.

module tb_ysram_port_arbiter;

   localparam int NRD = 4, NWR = 2, ADDR_W = 11, DATA_W = 256, DEPTH = 1800;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NRD-1:0]        rd_req;
   logic [NRD*ADDR_W-1:0] rd_addr;
   logic [NRD-1:0]        rd_gnt, rd_vld, rd_err;
   logic [NRD*DATA_W-1:0] rd_data;
   logic [NWR-1:0]        wr_req;
   logic [NWR*ADDR_W-1:0] wr_addr;
   logic [NWR*DATA_W-1:0] wr_data;
   logic [NWR-1:0]        wr_gnt, wr_err;
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_waddr, mem_raddr1, mem_raddr2;
   logic [DATA_W-1:0]     mem_wdata, mem_rdata1, mem_rdata2;

   logic [DATA_W-1:0] mem [0:DEPTH-1];

   localparam logic [DATA_W-1:0] D0     = {8{32'h1111_0000}};
   localparam logic [DATA_W-1:0] D1     = {8{32'h2222_0000}};
   localparam logic [DATA_W-1:0] DATA_A = {8{32'hA5A5_5A5A}};

   int n_chk  = 0;
   int n_pass = 0;

   ysram_port_arbiter #(.NRD(NRD), .NWR(NWR), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .i_clock(clk), .i_reset(reset),
      .i_rd_req(rd_req), .i_rd_addr(rd_addr),
      .o_rd_gnt(rd_gnt), .o_rd_vld(rd_vld), .o_rd_err(rd_err), .o_rd_data(rd_data),
      .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .o_wr_gnt(wr_gnt), .o_wr_err(wr_err),
      .o_mem_we(mem_we), .o_mem_waddr(mem_waddr), .o_mem_wdata(mem_wdata),
      .o_mem_raddr1(mem_raddr1), .o_mem_raddr2(mem_raddr2),
      .i_mem_rdata1(mem_rdata1), .i_mem_rdata2(mem_rdata2)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] word_of(input int a);
      return {8{32'hC0DE_0000 | 32'(a)}};
   endfunction

   // Asynchronous-read, synchronous-write memory model.
   assign mem_rdata1 = (mem_raddr1 < 11'(DEPTH)) ? mem[mem_raddr1] : '0;
   assign mem_rdata2 = (mem_raddr2 < 11'(DEPTH)) ? mem[mem_raddr2] : '0;

   always @(posedge clk) begin
      if (mem_we && !reset && mem_waddr < 11'(DEPTH)) mem[mem_waddr] <= mem_wdata;
   end

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd_addr(input int a0, input int a1, input int a2, input int a3);
      rd_addr = {11'(a3), 11'(a2), 11'(a1), 11'(a0)};
   endtask

   task automatic set_wr(input int a0, input logic [DATA_W-1:0] d0,
                         input int a1, input logic [DATA_W-1:0] d1);
      wr_addr = {11'(a1), 11'(a0)};
      wr_data = {d1, d0};
   endtask

   function automatic logic [DATA_W-1:0] rd_slice(input int i);
      return rd_data[i*DATA_W +: DATA_W];
   endfunction

   typedef struct packed {
      logic [3:0]  rd_req;
      logic [1:0]  wr_req;
      logic [3:0]  exp_rd_gnt;
      logic [1:0]  exp_wr_gnt;
      logic [3:0]  exp_rd_vld;
      logic        exp_mem_we;
      logic [10:0] exp_mem_waddr;
   } vec_t;

   vec_t vecs [12];

   initial begin
      for (int a = 0; a < DEPTH; a++) mem[a] = word_of(a);

      // Reads: requester i at address 10*(i+1). Writes: w0 -> 100/D0, w1 -> 200/D1.
      //            rd_req   wr_req  rd_gnt   wr_gnt  rd_vld   we    waddr
      vecs[0]  = '{4'b1111, 2'b00, 4'b0011, 2'b00, 4'b0000, 1'b0, 11'd0};
      vecs[1]  = '{4'b1111, 2'b00, 4'b1100, 2'b00, 4'b0000, 1'b0, 11'd0};
      vecs[2]  = '{4'b1111, 2'b00, 4'b0011, 2'b00, 4'b0011, 1'b0, 11'd0};
      vecs[3]  = '{4'b0000, 2'b11, 4'b0000, 2'b01, 4'b1100, 1'b0, 11'd0};
      vecs[4]  = '{4'b0000, 2'b11, 4'b0000, 2'b10, 4'b0011, 1'b1, 11'd100};
      vecs[5]  = '{4'b0000, 2'b11, 4'b0000, 2'b01, 4'b0000, 1'b1, 11'd200};
      vecs[6]  = '{4'b0000, 2'b11, 4'b0000, 2'b10, 4'b0000, 1'b1, 11'd100};
      vecs[7]  = '{4'b0100, 2'b00, 4'b0100, 2'b00, 4'b0000, 1'b1, 11'd200};
      vecs[8]  = '{4'b1001, 2'b00, 4'b1001, 2'b00, 4'b0000, 1'b0, 11'd200};
      vecs[9]  = '{4'b0001, 2'b00, 4'b0001, 2'b00, 4'b0100, 1'b0, 11'd200};
      vecs[10] = '{4'b0000, 2'b00, 4'b0000, 2'b00, 4'b1001, 1'b0, 11'd200};
      vecs[11] = '{4'b0000, 2'b00, 4'b0000, 2'b00, 4'b0001, 1'b0, 11'd200};

      // ---- reset values (requests asserted to show grants are blocked)
      reset  = 1'b1;
      rd_req = 4'b1111;
      wr_req = 2'b11;
      set_rd_addr(10, 20, 30, 40);
      set_wr(100, D0, 200, D1);
      tick(); tick(); tick();
      chk("reset_rd_gnt",    256'(rd_gnt), 256'(0));
      chk("reset_wr_gnt",    256'(wr_gnt), 256'(0));
      chk("reset_rd_vld",    256'(rd_vld), 256'(0));
      chk("reset_rd_err",    256'(rd_err), 256'(0));
      chk("reset_rd_data",   256'(rd_data != '0), 256'(0));
      chk("reset_mem_we",    256'(mem_we), 256'(0));
      chk("reset_mem_addrs", 256'({mem_waddr, mem_raddr1, mem_raddr2}), 256'(0));
      chk("reset_mem_wdata", mem_wdata, 256'(0));

      reset  = 1'b0;
      rd_req = '0;
      wr_req = '0;
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("idle_rd_vld", 256'(rd_vld), 256'(0));
         chk("idle_mem_we", 256'(mem_we), 256'(0));
      end

      // ---- table: round-robin reads, write fairness, pointer wrap
      for (int v = 0; v < 12; v++) begin
         rd_req = vecs[v].rd_req;
         wr_req = vecs[v].wr_req;
         #1;
         chk($sformatf("v%0d_rd_gnt", v),    256'(rd_gnt),    256'(vecs[v].exp_rd_gnt));
         chk($sformatf("v%0d_wr_gnt", v),    256'(wr_gnt),    256'(vecs[v].exp_wr_gnt));
         chk($sformatf("v%0d_wr_err", v),    256'(wr_err),    256'(0));
         chk($sformatf("v%0d_rd_vld", v),    256'(rd_vld),    256'(vecs[v].exp_rd_vld));
         chk($sformatf("v%0d_mem_we", v),    256'(mem_we),    256'(vecs[v].exp_mem_we));
         chk($sformatf("v%0d_mem_waddr", v), 256'(mem_waddr), 256'(vecs[v].exp_mem_waddr));
         if (vecs[v].exp_mem_we)
            chk($sformatf("v%0d_mem_wdata", v), mem_wdata,
                (vecs[v].exp_mem_waddr == 11'd100) ? D0 : D1);
         for (int i = 0; i < NRD; i++)
            if (vecs[v].exp_rd_vld[i])
               chk($sformatf("v%0d_rd_data%0d", v, i), rd_slice(i), word_of(10*(i+1)));
         tick();
      end
      rd_req = '0;
      wr_req = '0;

      // ---- same-address read and write (rp=1, wp=0 here)
      set_rd_addr(0, 5, 5, 0);
      set_wr(5, DATA_A, 0, D1);
      rd_req = 4'b0010;
      wr_req = 2'b01;
      #1;
      chk("rw_same_rd_gnt", 256'(rd_gnt), 256'(4'b0010));
      chk("rw_same_wr_gnt", 256'(wr_gnt), 256'(2'b01));
      tick();
      rd_req = 4'b0100;
      wr_req = 2'b00;
      #1;
      chk("rw_next_rd_gnt", 256'(rd_gnt), 256'(4'b0100));
      chk("rw_mem_we",      256'(mem_we), 256'(1));
      chk("rw_mem_waddr",   256'(mem_waddr), 256'(5));
      chk("rw_mem_wdata",   mem_wdata, DATA_A);
      tick();
      rd_req = '0;
      chk("rw_old_vld",  256'(rd_vld), 256'(4'b0010));
      chk("rw_old_data", rd_slice(1), word_of(5));
      tick();
      chk("rw_new_vld",  256'(rd_vld), 256'(4'b0100));
      chk("rw_new_data", rd_slice(2), DATA_A);
      chk("rw_hold_data", rd_slice(1), word_of(5));

      // ---- out-of-range read and write (rp=3, wp=1 here)
      set_rd_addr(0, 0, 0, 1800);
      set_wr(0, D0, 2047, D1);
      rd_req = 4'b1000;
      wr_req = 2'b10;
      #1;
      chk("oor_rd_gnt", 256'(rd_gnt), 256'(4'b1000));
      chk("oor_wr_gnt", 256'(wr_gnt), 256'(2'b10));
      chk("oor_wr_err", 256'(wr_err), 256'(2'b10));
      tick();
      rd_req = '0;
      wr_req = '0;
      chk("oor_mem_we",     256'(mem_we), 256'(0));
      chk("oor_mem_raddr1", 256'(mem_raddr1), 256'(5));
      chk("oor_mem_raddr2", 256'(mem_raddr2), 256'(10));
      tick();
      chk("oor_rd_vld",  256'(rd_vld), 256'(4'b1000));
      chk("oor_rd_err",  256'(rd_err), 256'(4'b1000));
      chk("oor_rd_data", rd_slice(3), 256'(0));
      chk("oor_mem_we2", 256'(mem_we), 256'(0));
      tick();
      chk("oor_vld_drop", 256'(rd_vld), 256'(0));

      // ---- reset mid-flight (rp=0 here; grant moves it to 2)
      set_rd_addr(10, 20, 30, 40);
      rd_req = 4'b0011;
      #1;
      chk("rst_pre_gnt", 256'(rd_gnt), 256'(4'b0011));
      tick();
      rd_req = '0;
      reset  = 1'b1;
      #1;
      chk("rst_gnt_blocked", 256'(rd_gnt), 256'(0));
      tick();
      chk("rst_no_vld_a", 256'(rd_vld), 256'(0));
      tick();
      reset  = 1'b0;
      rd_req = 4'b1111;
      #1;
      chk("rst_no_vld_b", 256'(rd_vld), 256'(0));
      chk("rst_rp_zero",  256'(rd_gnt), 256'(4'b0011));
      tick();
      rd_req = '0;
      chk("rst_no_vld_c", 256'(rd_vld), 256'(0));
      tick();
      chk("rst_after_vld",   256'(rd_vld), 256'(4'b0011));
      chk("rst_after_data0", rd_slice(0), word_of(10));
      chk("rst_after_data1", rd_slice(1), word_of(20));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ysram_port_arbiter.md
# ysram_port_arbiter

- Shares the 1800 × 256-bit Y-memory between multiple requesters. The memory has two read ports and one write port.
- Each cycle it grants up to two read requesters and one write requester using round-robin. It drives registered addresses, write enable and write data into the memory.
- It captures read data and returns it to the requester that issued the read, tagged per requester.
- It rejects out-of-range addresses without touching memory.

## Interface

Parameters:
- NRD, 4: number of read requesters.
- NWR, 2: number of write requesters.
- ADDR_W, 11: address width.
- DATA_W, 256: word width.
- DEPTH, 1800: valid addresses are 0..DEPTH-1.

Ports:
- clock  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- rd_req  in  NRD  read request, one bit per requester. Held with rd_addr until rd_gnt.
- rd_addr  in  NRD*ADDR_W  read address; requester i uses slice [i*ADDR_W +: ADDR_W].
- rd_gnt  out  NRD  combinational; one-cycle acceptance per requester.
- rd_vld  out  NRD  registered; response valid for requester i.
- rd_err  out  NRD  registered; asserted together with rd_vld when the address was out of range.
- rd_data  out  NRD*DATA_W  registered response data, per-requester slice.
- wr_req  in  NWR  write request; held with wr_addr and wr_data until wr_gnt.
- wr_addr  in  NWR*ADDR_W  write address.
- wr_data  in  NWR*DATA_W  write data.
- wr_gnt  out  NWR  combinational acceptance.
- wr_err  out  NWR  combinational; asserted with wr_gnt when wr_addr ≥ DEPTH.
- mem_we  out  1  registered write enable to memory.
- mem_waddr  out  ADDR_W  registered memory write address.
- mem_wdata  out  DATA_W  registered memory write data.
- mem_raddr1  out  ADDR_W  registered address for memory read port 1.
- mem_raddr2  out  ADDR_W  registered address for memory read port 2.
- mem_rdata1  in  DATA_W  data from memory read port 1.
- mem_rdata2  in  DATA_W  data from memory read port 2.

## Operation

**Read arbitration**
- Uses a pointer rp, range 0..NRD-1.
- Port 1 goes to the first requesting index at or after rp, scanning cyclically.
- Port 2 goes to the next requesting index after that one.
- Granting zero, one or two requesters per cycle is legal.
- After any grant, rp is set to (last granted index + 1) mod NRD; otherwise rp is unchanged.
- Starvation bound: a held request is granted within ceil(NRD/2) cycles.

**Write arbitration**
- Uses a pointer wp with the same cyclic scan, one grant per cycle.
- After a grant, wp advances to (granted index + 1) mod NWR.

**Out-of-range addresses**
- Read with address ≥ DEPTH: the requester is granted and consumes a port slot. No memory access is made. The response is rd_vld=1, rd_err=1, rd_data=0.
- Write with address ≥ DEPTH: wr_gnt=1 and wr_err=1; mem_we stays 0.

**Per-port tags**
- Each read port carries a registered tag: valid bit, requester index and error bit. The tag follows the address down the pipeline.
- When a tag retires with valid=1, the arbiter sets rd_vld[index] and loads that requester's rd_data slice from the matching mem_rdata bus.
- If both ports return in one cycle, they always belong to distinct requesters, so no conflict exists.

**Idle outputs**
- With no grant, mem_raddr1 and mem_raddr2 hold their last values and mem_we=0.

**Same-address read and write**
- A read and a write granted in the same cycle to the same address: the read returns the pre-write contents.
- A read granted one or more cycles after the write's grant returns the new data.

## Timing

- Cycle T: requests sampled; grants combinational.
- Edge end of T: mem_* registers loaded.
- Cycle T+1: memory addresses stable. The write commits at the edge ending T+1.
- Read data is sampled at the edge ending T+1.
- Cycle T+2: rd_vld, rd_err and rd_data valid for exactly one cycle.
- Read latency from grant to response is 2 cycles, fully pipelined. Throughput is 2 reads plus 1 write per cycle.
- rd_data holds its value after rd_vld drops, until the next response for that requester.
- A requester may reassert rd_req with a new address in the cycle after its rd_gnt.

**Reset**
- Sampled while reset=1: rp=0, wp=0, all tags invalid.
- mem_we=0, mem_raddr1=mem_raddr2=mem_waddr=0, mem_wdata=0.
- rd_vld=0, rd_err=0, rd_data=0.
- rd_gnt=0 and wr_gnt=0 while reset is high.
- Reads granted in the cycle before reset asserts produce no response.
- A write registered before reset asserts is cancelled, because mem_we is cleared in the same edge.

## Test plan

- **Reset values:** hold reset 3 cycles. Every output is 0; after release with no requests, rd_vld and mem_we stay 0.
- **Round-robin reads:** all four rd_req held with addresses 10, 20, 30, 40.
  - Grants are {0,1} then {2,3} then {0,1}.
  - Responses arrive 2 cycles after each grant with the preloaded memory words at those addresses.
- **Write then read:**
  - Same cycle: write req0 addr 5 data A with a read of addr 5. Read returns the old word.
  - Next cycle: read addr 5 again. Read returns A.
- **Out-of-range:**
  - rd_addr 1800 gives rd_gnt, then 2 cycles later rd_vld=1, rd_err=1, rd_data=0, with no change to mem_raddr.
  - wr_addr 2047 gives wr_gnt=1, wr_err=1, and mem_we stays 0.
- **Write fairness:** both writers request continuously with distinct addresses.
  - wr_gnt alternates 0,1,0,1.
  - mem_waddr and mem_wdata follow one cycle later.
- **Reset mid-flight:**
  - Grant reads {0,1}, then assert reset in the next cycle.
  - No rd_vld appears for those reads; after release, rp restarts at 0.
